// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo sample FIFO between a DSP producer and a codec serializer, with priming and underflow tracking
module audio_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int PRIME = DEPTH / 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [15:0]        in_left,
  input  logic signed [15:0]        in_right,
  input  logic                      frame_req,
  output logic signed [15:0]        out_left,
  output logic signed [15:0]        out_right,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      running,
  output logic [15:0]               underflow_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {FILLING, RUNNING} state_t;
  state_t                  r_state;
  logic [31:0]             r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]           r_level;
  logic signed [15:0]      r_out_l, r_out_r;
  logic [15:0]             r_uf;
  logic                    w_push, w_pop, w_under;
  logic [LW-1:0]           w_level_nx;
  assign in_ready        = r_level != LW'(DEPTH);
  assign w_push          = in_valid && in_ready;
  assign w_pop           = frame_req && r_state == RUNNING && r_level != '0;
  assign w_under         = frame_req && r_state == RUNNING && r_level == '0;
  assign w_level_nx      = r_level + LW'(w_push) - LW'(w_pop);
  assign level           = r_level;
  assign running         = r_state == RUNNING;
  assign out_left        = r_out_l;
  assign out_right       = r_out_r;
  assign underflow_count = r_uf;
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr_ptr] <= {in_left, in_right};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= FILLING;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_out_l  <= '0;
      r_out_r  <= '0;
      r_uf     <= '0;
    end else begin
      r_level <= w_level_nx;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      // a request that cannot pop (filling or underflow) plays silence
      if (frame_req) {r_out_l, r_out_r} <= w_pop ? r_mem[r_rd_ptr] : 32'd0;
      if (w_under && r_uf != 16'hFFFF) r_uf <= r_uf + 16'd1;
      // underflow takes priority: re-prime before resuming playback
      if (r_state == RUNNING) r_state <= w_under ? FILLING : RUNNING;
      else r_state <= w_level_nx >= LW'(PRIME) ? RUNNING : FILLING;
    end
  end
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed table-driven checks of audio_sample_fifo with DEPTH=8, PRIME=4
module tb_audio_sample_fifo;
  logic               clock = 0, reset = 1, in_valid = 0, frame_req = 0;
  logic               in_ready, running;
  logic signed [15:0] in_left = 0, in_right = 0, out_left, out_right;
  logic [3:0]         level;
  logic [15:0]        underflow_count;
  int                 n_pass = 0, n_total = 0;
  typedef struct {
    logic        iv;
    logic [15:0] l, r;
    logic        fr;
    logic [3:0]  lv;
    logic        rn, rd;
    logic [15:0] ol, o_r, uf;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] q[$];
  logic [31:0] e;
  audio_sample_fifo #(.DEPTH(8), .PRIME(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .frame_req(frame_req),
    .out_left(out_left), .out_right(out_right), .level(level),
    .running(running), .underflow_count(underflow_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic vec_t v(logic iv, logic [15:0] l, logic [15:0] r, logic fr, logic [3:0] lv,
                             logic rn, logic rd, logic [15:0] ol, logic [15:0] o_r, logic [15:0] uf);
    vec_t x;
    x.iv = iv; x.l = l; x.r = r; x.fr = fr; x.lv = lv;
    x.rn = rn; x.rd = rd; x.ol = ol; x.o_r = o_r; x.uf = uf;
    return x;
  endfunction
  task automatic check_all(input string tag, input logic [3:0] lv, input logic rn, input logic rd,
                           input logic [15:0] ol, input logic [15:0] o_r, input logic [15:0] uf);
    chk({tag, ".level"}, 16'(level), 16'(lv));
    chk({tag, ".running"}, 16'(running), 16'(rn));
    chk({tag, ".in_ready"}, 16'(in_ready), 16'(rd));
    chk({tag, ".out_left"}, out_left, ol);
    chk({tag, ".out_right"}, out_right, o_r);
    chk({tag, ".uf_count"}, underflow_count, uf);
  endtask
  initial begin
    // priming, pops, simultaneous push+pop, underflow (with push on same edge)
    tbl.push_back(v(1, 16'h0100, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h0000, 0));
    tbl.push_back(v(1, 16'h0101, 16'hFFFF, 0, 2, 0, 1, 16'h0000, 16'h0000, 0));
    tbl.push_back(v(1, 16'h0102, 16'hFFFE, 0, 3, 0, 1, 16'h0000, 16'h0000, 0));
    tbl.push_back(v(1, 16'h0103, 16'hFFFD, 0, 4, 1, 1, 16'h0000, 16'h0000, 0));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 3, 1, 1, 16'h0100, 16'h0000, 0));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 0, 3, 1, 1, 16'h0100, 16'h0000, 0));
    tbl.push_back(v(1, 16'h0104, 16'hFFFC, 1, 3, 1, 1, 16'h0101, 16'hFFFF, 0));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 2, 1, 1, 16'h0102, 16'hFFFE, 0));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h0103, 16'hFFFD, 0));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 0, 1, 1, 16'h0104, 16'hFFFC, 0));
    tbl.push_back(v(1, 16'h0200, 16'h1111, 1, 1, 0, 1, 16'h0000, 16'h0000, 1));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h0000, 16'h0000, 1));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h0000, 16'h0000, 1));
    // fill past full: level 1 -> 8 after 7 pushes, remaining 3 discarded
    for (int k = 0; k < 10; k++)
      tbl.push_back(v(1, 16'h0300 + 16'(k), 16'h0400 + 16'(k), 0, (k < 7) ? 4'(2 + k) : 4'd8,
                      k >= 2, k < 6, 16'h0000, 16'h0000, 1));
    // drain: only the stored entries come out
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 7, 1, 1, 16'h0200, 16'h1111, 1));
    for (int k = 1; k < 8; k++)
      tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 4'(7 - k), 1, 1, 16'h0300 + 16'(k - 1),
                      16'h0400 + 16'(k - 1), 1));
    tbl.push_back(v(0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000, 2));
    #3;
    check_all("reset", 0, 0, 1, 0, 0, 0);
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv; in_left = tbl[i].l; in_right = tbl[i].r; frame_req = tbl[i].fr;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].lv, tbl[i].rn, tbl[i].rd, tbl[i].ol, tbl[i].o_r, tbl[i].uf);
    end
    // wrap-around: 20 pushes and 20 pops interleaved, checked against an in-order queue
    for (int j = 0; j < 24; j++) begin
      in_valid = j < 20;
      in_left = 16'h1000 + 16'(j);
      in_right = ~(16'h2000 + 16'(j));
      frame_req = j >= 4;
      if (j < 20) q.push_back({in_left, in_right});
      step();
      if (j >= 4) begin
        e = q.pop_front();
        chk($sformatf("wrap%0d.left", j), out_left, e[31:16]);
        chk($sformatf("wrap%0d.right", j), out_right, e[15:0]);
      end
    end
    in_valid = 0; frame_req = 0;
    chk("wrap.level", 16'(level), 0);
    chk("wrap.running", 16'(running), 1);
    // asynchronous reset mid-operation at level 5
    for (int j = 0; j < 6; j++) begin
      in_valid = 1; in_left = 16'h5000 + 16'(j); in_right = 16'h6000 + 16'(j);
      step();
    end
    in_valid = 0; frame_req = 1;
    step();
    frame_req = 0;
    check_all("pre_rst", 5, 1, 1, 16'h5000, 16'h6000, 2);
    #3 reset = 1;
    #1 check_all("async_rst", 0, 0, 1, 0, 0, 0);
    #2 reset = 0;
    in_valid = 1; in_left = 16'h7777; in_right = 16'h8888;
    step();
    in_valid = 0;
    chk("post_rst.level", 16'(level), 1);
    chk("post_rst.running", 16'(running), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
